zap_wb_merger: RTL and testbench

ZAP_WB_MERGER -- requirements
Module: zap_wb_merger

---
 rtl/zap_wb_merger.sv | 128 ++++++++++++
 tb/tb_zap_wb_merger.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/zap_wb_merger.sv
// Two-master Wishbone merger: the cache FSM (master 0) and the TLB FSM
// (master 1) share one registered external Wishbone master port.
// Ownership is held until the owner drops cyc_nxt. Ties go to the master
// that did not win last time.
module zap_wb_merger #(
  parameter bit FIRST_GRANT = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  // Cache FSM (master 0), next-cycle signals
  input  logic        i_c_wb_cyc_nxt,
  input  logic        i_c_wb_stb_nxt,
  input  logic        i_c_wb_wen_nxt,
  input  logic [3:0]  i_c_wb_sel_nxt,
  input  logic [31:0] i_c_wb_adr_nxt,
  input  logic [31:0] i_c_wb_dat_nxt,
  // TLB FSM (master 1, read only), next-cycle signals
  input  logic        i_t_wb_cyc_nxt,
  input  logic        i_t_wb_stb_nxt,
  input  logic [3:0]  i_t_wb_sel_nxt,
  input  logic [31:0] i_t_wb_adr_nxt,
  // Per-master response
  output logic        o_c_wb_ack,
  output logic        o_t_wb_ack,
  output logic [31:0] o_wb_dat,
  // External Wishbone master port
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_wen,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat_w,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_dat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_C = 2'd1,
    GNT_T = 2'd2
  } state_t;

  state_t state_ff;
  state_t state_nxt;
  logic   last_ff;

  // Grant decision: the owner keeps the bus while it requests, otherwise
  // hand off directly to the other master; ties from IDLE go to !last_ff.
  always_comb begin
    state_nxt = IDLE;
    case (state_ff)
      IDLE: begin
        if (i_c_wb_cyc_nxt && i_t_wb_cyc_nxt)
          state_nxt = last_ff ? GNT_C : GNT_T;
        else if (i_c_wb_cyc_nxt)
          state_nxt = GNT_C;
        else if (i_t_wb_cyc_nxt)
          state_nxt = GNT_T;
      end
      GNT_C: begin
        if (i_c_wb_cyc_nxt)
          state_nxt = GNT_C;
        else if (i_t_wb_cyc_nxt)
          state_nxt = GNT_T;
      end
      GNT_T: begin
        if (i_t_wb_cyc_nxt)
          state_nxt = GNT_T;
        else if (i_c_wb_cyc_nxt)
          state_nxt = GNT_C;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, last-grant memory and the registered port, loaded from whichever
  // master the grant lands on this edge (zeros when nobody owns the bus).
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_ff   <= IDLE;
      last_ff    <= ~FIRST_GRANT;
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_wen   <= 1'b0;
      o_wb_sel   <= 4'h0;
      o_wb_adr   <= 32'h0;
      o_wb_dat_w <= 32'h0;
    end else begin
      state_ff <= state_nxt;
      case (state_nxt)
        GNT_C: begin
          last_ff    <= 1'b0;
          o_wb_cyc   <= i_c_wb_cyc_nxt;
          o_wb_stb   <= i_c_wb_stb_nxt;
          o_wb_wen   <= i_c_wb_wen_nxt;
          o_wb_sel   <= i_c_wb_sel_nxt;
          o_wb_adr   <= i_c_wb_adr_nxt;
          o_wb_dat_w <= i_c_wb_dat_nxt;
        end
        GNT_T: begin
          // The TLB only reads, so the write side is forced quiet.
          last_ff    <= 1'b1;
          o_wb_cyc   <= i_t_wb_cyc_nxt;
          o_wb_stb   <= i_t_wb_stb_nxt;
          o_wb_wen   <= 1'b0;
          o_wb_sel   <= i_t_wb_sel_nxt;
          o_wb_adr   <= i_t_wb_adr_nxt;
          o_wb_dat_w <= 32'h0;
        end
        default: begin
          o_wb_cyc   <= 1'b0;
          o_wb_stb   <= 1'b0;
          o_wb_wen   <= 1'b0;
          o_wb_sel   <= 4'h0;
          o_wb_adr   <= 32'h0;
          o_wb_dat_w <= 32'h0;
        end
      endcase
    end
  end

  // Acks reach only the current owner, and only while a cycle is open, so
  // the waiting master keeps its request up and stray acks are dropped.
  assign o_c_wb_ack = i_wb_ack & (state_ff == GNT_C) & o_wb_cyc;
  assign o_t_wb_ack = i_wb_ack & (state_ff == GNT_T) & o_wb_cyc;
  assign o_wb_dat   = i_wb_dat;

endmodule

// File: tb/tb_zap_wb_merger.sv
// Scoreboard bench for zap_wb_merger: directed vectors push hand-computed
// port expectations; a monitor pops and compares one entry per clock.
module tb_zap_wb_merger;

  logic        clk;
  logic        rst_n;
  logic        c_cyc, c_stb, c_wen;
  logic [3:0]  c_sel;
  logic [31:0] c_adr, c_dat;
  logic        t_cyc, t_stb;
  logic [3:0]  t_sel;
  logic [31:0] t_adr;
  logic        c_ack, t_ack;
  logic [31:0] rd_dat;
  logic        wb_cyc, wb_stb, wb_wen;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_w;
  logic        wb_ack;
  logic [31:0] wb_rdat;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        cyc;
    logic        wen;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] datw;
    logic [31:0] rdat;
    logic        cack;
    logic        tack;
  } exp_t;

  exp_t exp_q[$];

  zap_wb_merger #(.FIRST_GRANT(1'b0)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_c_wb_cyc_nxt (c_cyc),
    .i_c_wb_stb_nxt (c_stb),
    .i_c_wb_wen_nxt (c_wen),
    .i_c_wb_sel_nxt (c_sel),
    .i_c_wb_adr_nxt (c_adr),
    .i_c_wb_dat_nxt (c_dat),
    .i_t_wb_cyc_nxt (t_cyc),
    .i_t_wb_stb_nxt (t_stb),
    .i_t_wb_sel_nxt (t_sel),
    .i_t_wb_adr_nxt (t_adr),
    .o_c_wb_ack     (c_ack),
    .o_t_wb_ack     (t_ack),
    .o_wb_dat       (rd_dat),
    .o_wb_cyc       (wb_cyc),
    .o_wb_stb       (wb_stb),
    .o_wb_wen       (wb_wen),
    .o_wb_sel       (wb_sel),
    .o_wb_adr       (wb_adr),
    .o_wb_dat_w     (wb_dat_w),
    .i_wb_ack       (wb_ack),
    .i_wb_dat       (wb_rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of next-cycle requests on the falling edge and queue
  // what the port must show just after the following rising edge.
  task automatic vec(input logic c_cyc_i, input logic c_wen_i,
                     input logic [31:0] c_adr_i, input logic [31:0] c_dat_i,
                     input logic t_cyc_i, input logic [31:0] t_adr_i,
                     input logic ack_i, input logic [31:0] rdat_i,
                     input logic e_cyc, input logic e_wen, input logic [3:0] e_sel,
                     input logic [31:0] e_adr, input logic [31:0] e_datw,
                     input logic e_cack, input logic e_tack);
    exp_t e;
    @(negedge clk);
    c_cyc   = c_cyc_i;
    c_stb   = c_cyc_i;
    c_wen   = c_wen_i;
    c_sel   = 4'h3;
    c_adr   = c_adr_i;
    c_dat   = c_dat_i;
    t_cyc   = t_cyc_i;
    t_stb   = t_cyc_i;
    t_sel   = 4'hF;
    t_adr   = t_adr_i;
    wb_ack  = ack_i;
    wb_rdat = rdat_i;
    e.cyc  = e_cyc;
    e.wen  = e_wen;
    e.sel  = e_sel;
    e.adr  = e_adr;
    e.datw = e_datw;
    e.rdat = rdat_i;
    e.cack = e_cack;
    e.tack = e_tack;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per rising edge, compared 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cyc",   {31'h0, wb_cyc},   {31'h0, e.cyc});
        check("stb",   {31'h0, wb_stb},   {31'h0, e.cyc});
        check("wen",   {31'h0, wb_wen},   {31'h0, e.wen});
        check("sel",   {28'h0, wb_sel},   {28'h0, e.sel});
        check("adr",   wb_adr,            e.adr);
        check("dat_w", wb_dat_w,          e.datw);
        check("rdat",  rd_dat,            e.rdat);
        check("c_ack", {31'h0, c_ack},    {31'h0, e.cack});
        check("t_ack", {31'h0, t_ack},    {31'h0, e.tack});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    c_cyc = 0; c_stb = 0; c_wen = 0; c_sel = 0; c_adr = 0; c_dat = 0;
    t_cyc = 0; t_stb = 0; t_sel = 0; t_adr = 0;
    wb_ack = 0; wb_rdat = 0;

    // Held in reset: requests and acks have no effect.
    vec(1, 1, 32'h10, 32'h99, 1, 32'h20, 1, 32'h11, 0, 0, 4'h0, 0, 0, 0, 0);
    vec(1, 0, 32'h14, 32'h0,  1, 32'h24, 1, 32'h12, 0, 0, 4'h0, 0, 0, 0, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Tie right after reset: cache first, then hand-off to TLB with no gap.
    vec(1, 0, 32'h200, 0, 1, 32'h4000, 0, 32'hA0, 1, 0, 4'h3, 32'h200,  0, 0, 0);
    vec(1, 0, 32'h204, 0, 1, 32'h4000, 1, 32'hA1, 1, 0, 4'h3, 32'h204,  0, 1, 0);
    vec(0, 0, 32'h0,   0, 1, 32'h4000, 0, 32'hA2, 1, 0, 4'hF, 32'h4000, 0, 0, 0);
    vec(0, 0, 32'h0,   0, 1, 32'h4000, 1, 32'hA3, 1, 0, 4'hF, 32'h4000, 0, 0, 1);
    vec(0, 0, 0, 0, 0, 0, 0, 32'hA4, 0, 0, 4'h0, 0, 0, 0, 0);

    // Spurious ack while idle, then a single TLB read.
    vec(0, 0, 0, 0, 0, 0, 1, 32'h5A5A5A5A, 0, 0, 4'h0, 0, 0, 0, 0);
    vec(0, 0, 0, 0, 1, 32'h4008, 0, 32'h0,        1, 0, 4'hF, 32'h4008, 0, 0, 0);
    vec(0, 0, 0, 0, 1, 32'h4008, 1, 32'hCAFE0001, 1, 0, 4'hF, 32'h4008, 0, 0, 1);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);

    // Tie with TLB last: cache wins and holds a 4-beat burst against a
    // waiting TLB, which only gets the bus once the cache lets go.
    vec(1, 0, 32'h300, 0, 1, 32'h5000, 1, 32'hB0, 1, 0, 4'h3, 32'h300,  0, 1, 0);
    vec(1, 0, 32'h304, 0, 1, 32'h5000, 1, 32'hB1, 1, 0, 4'h3, 32'h304,  0, 1, 0);
    vec(1, 0, 32'h308, 0, 1, 32'h5000, 1, 32'hB2, 1, 0, 4'h3, 32'h308,  0, 1, 0);
    vec(1, 0, 32'h30C, 0, 1, 32'h5000, 1, 32'hB3, 1, 0, 4'h3, 32'h30C,  0, 1, 0);
    vec(0, 0, 32'h0,   0, 1, 32'h5000, 0, 32'hB4, 1, 0, 4'hF, 32'h5000, 0, 0, 0);
    vec(1, 0, 32'h400, 0, 1, 32'h5004, 1, 32'hB5, 1, 0, 4'hF, 32'h5004, 0, 0, 1);
    vec(1, 0, 32'h400, 0, 0, 32'h0,    0, 32'hB6, 1, 0, 4'h3, 32'h400,  0, 0, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);

    // Cache write.
    vec(1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, 4'h3, 32'h100, 32'hDEADBEEF, 0, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);

    // TLB owns the bus while the cache idles with write controls up:
    // the write side stays quiet.
    vec(0, 1, 32'h0, 32'h12345678, 1, 32'h6000, 0, 0, 1, 0, 4'hF, 32'h6000, 0, 0, 0);
    vec(0, 1, 32'h0, 32'h12345678, 1, 32'h6004, 0, 0, 1, 0, 4'hF, 32'h6004, 0, 0, 0);

    // Reset mid-transfer: port drops at once, ack during reset is discarded.
    @(posedge clk);
    #2;
    wb_ack = 1'b1;
    rst_n  = 1'b0;
    #1;
    check("rst_cyc",   {31'h0, wb_cyc}, 32'h0);
    check("rst_stb",   {31'h0, wb_stb}, 32'h0);
    check("rst_adr",   wb_adr,          32'h0);
    check("rst_t_ack", {31'h0, t_ack},  32'h0);
    check("rst_c_ack", {31'h0, c_ack},  32'h0);
    vec(1, 0, 32'h700, 0, 1, 32'h7000, 1, 32'hC0, 0, 0, 4'h0, 0, 0, 0, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // First request after reset, then the owner keeps the bus on a tie.
    vec(0, 0, 32'h0,   0, 1, 32'h7000, 0, 0, 1, 0, 4'hF, 32'h7000, 0, 0, 0);
    vec(1, 0, 32'h800, 0, 1, 32'h7004, 1, 0, 1, 0, 4'hF, 32'h7004, 0, 0, 1);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
